ack_nack_scheduler: RTL and testbench

//  Downstream of the receiver packet checker. Drains its {ack/nack, id} result FIFO and turns each

---
 rtl/ack_nack_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_ack_nack_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ack_nack_scheduler.sv
// ACK/NACK DLLP scheduler: drains the receiver result FIFO and requests ACK/NACK DLLPs.
// Define ACK_NACK_COALESCE_EN to merge ACKs by count/timeout; otherwise each ACK is sent directly.
`timescale 1ns/1ps

module ack_nack_scheduler #(
    parameter int TLP_ID_WIDTH     = 2,
    parameter int ACK_COALESCE_MAX = 4,
    parameter int ACK_TIMEOUT      = 16
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_id_result_empty,
    input  logic [TLP_ID_WIDTH:0]   i_id_result,
    output logic                    o_id_result_rd,
    output logic                    o_dllp_req,
    input  logic                    i_dllp_ack,
    output logic [15:0]             o_dllp_data,
    output logic                    o_nack_pending
);

    localparam logic [3:0] S_IDLE     = 4'b0001;
    localparam logic [3:0] S_EVAL     = 4'b0010;
    localparam logic [3:0] S_COALESCE = 4'b0100;
    localparam logic [3:0] S_SEND     = 4'b1000;

    localparam logic [7:0] TYPE_ACK  = 8'hA0;
    localparam logic [7:0] TYPE_NACK = 8'hB0;

    if (TLP_ID_WIDTH < 1 || TLP_ID_WIDTH > 8 || ACK_COALESCE_MAX < 1 || ACK_TIMEOUT < 2) begin : g_param_check
        $error("ack_nack_scheduler: parameter out of range");
    end

    function automatic logic [15:0] make_dllp(input logic [7:0] dllp_type,
                                              input logic [TLP_ID_WIDTH-1:0] id);
        logic [7:0] id_ext;
        id_ext = '0;
        id_ext[TLP_ID_WIDTH-1:0] = id;
        return {dllp_type, id_ext};
    endfunction

    logic [3:0]              state_q, state_d;
    logic [TLP_ID_WIDTH:0]   entry_q, entry_d;
    logic [TLP_ID_WIDTH-1:0] last_nack_id_q, last_nack_id_d;
    logic                    nack_pending_q, nack_pending_d;
    logic [15:0]             dllp_data_q, dllp_data_d;
    logic                    pop;
    logic                    can_pop;
    logic                    entry_is_ack;
    logic [TLP_ID_WIDTH-1:0] entry_id;
    logic                    nack_dup;

    // Gating with reset keeps an entry from being popped and lost while reset is held.
    assign can_pop      = ~i_arst & ~i_id_result_empty;
    assign entry_is_ack = entry_q[TLP_ID_WIDTH];
    assign entry_id     = entry_q[TLP_ID_WIDTH-1:0];
    assign nack_dup     = nack_pending_q && (entry_id == last_nack_id_q);

`ifdef ACK_NACK_COALESCE_EN
    localparam int CNT_W = $clog2(ACK_COALESCE_MAX + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_COALESCE_MAX);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(ACK_TIMEOUT - 1);

    logic [TLP_ID_WIDTH-1:0] ack_id_q, ack_id_d;
    logic                    ack_pending_q, ack_pending_d;
    logic [CNT_W-1:0]        count_q, count_d, count_inc;
    logic [TMR_W-1:0]        timer_q, timer_d, timer_inc;
    logic                    timeout;

    // timer_q holds the pending-cycle index of the current cycle (the EVAL cycle is index 1),
    // so the forced send rises ACK_TIMEOUT cycles after the pop of the first ACK.
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    assign timeout   = ack_pending_q && (timer_q >= TMR_FIRE);
`endif

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q        <= S_IDLE;
            nack_pending_q <= 1'b0;
            dllp_data_q    <= '0;
`ifdef ACK_NACK_COALESCE_EN
            ack_pending_q  <= 1'b0;
            count_q        <= '0;
            timer_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            nack_pending_q <= nack_pending_d;
            dllp_data_q    <= dllp_data_d;
`ifdef ACK_NACK_COALESCE_EN
            ack_pending_q  <= ack_pending_d;
            count_q        <= count_d;
            timer_q        <= timer_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        entry_q        <= entry_d;
        last_nack_id_q <= last_nack_id_d;
`ifdef ACK_NACK_COALESCE_EN
        ack_id_q       <= ack_id_d;
`endif
    end

    always_comb begin
        state_d        = state_q;
        entry_d        = entry_q;
        last_nack_id_d = last_nack_id_q;
        nack_pending_d = nack_pending_q;
        dllp_data_d    = dllp_data_q;
        pop            = 1'b0;
`ifdef ACK_NACK_COALESCE_EN
        ack_id_d       = ack_id_q;
        ack_pending_d  = ack_pending_q;
        count_d        = count_q;
        timer_d        = ack_pending_q ? timer_inc : '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    entry_d = i_id_result;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (!entry_is_ack) begin
                    if (nack_dup) begin
`ifdef ACK_NACK_COALESCE_EN
                        state_d = ack_pending_q ? S_COALESCE : S_IDLE;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        // A fresh NACK supersedes whatever ACK was being coalesced.
`ifdef ACK_NACK_COALESCE_EN
                        ack_pending_d = 1'b0;
                        count_d       = '0;
                        timer_d       = '0;
`endif
                        dllp_data_d    = make_dllp(TYPE_NACK, entry_id);
                        last_nack_id_d = entry_id;
                        nack_pending_d = 1'b1;
                        state_d        = S_SEND;
                    end
                end else begin
                    nack_pending_d = 1'b0;
`ifdef ACK_NACK_COALESCE_EN
                    ack_id_d      = entry_id;
                    ack_pending_d = 1'b1;
                    count_d       = count_inc;
                    timer_d       = ack_pending_q ? timer_inc : TMR_W'(2);
                    if (count_inc == CNT_MAX) begin
                        dllp_data_d = make_dllp(TYPE_ACK, entry_id);
                        state_d     = S_SEND;
                    end else begin
                        state_d     = S_COALESCE;
                    end
`else
                    dllp_data_d = make_dllp(TYPE_ACK, entry_id);
                    state_d     = S_SEND;
`endif
                end
            end
            S_COALESCE: begin
`ifdef ACK_NACK_COALESCE_EN
                if (timeout) begin
                    dllp_data_d = make_dllp(TYPE_ACK, ack_id_q);
                    state_d     = S_SEND;
                end else if (can_pop) begin
                    pop     = 1'b1;
                    entry_d = i_id_result;
                    state_d = S_EVAL;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_SEND: begin
                if (i_dllp_ack) begin
`ifdef ACK_NACK_COALESCE_EN
                    ack_pending_d = 1'b0;
                    count_d       = '0;
                    timer_d       = '0;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_id_result_rd = pop;
        o_dllp_req     = (state_q == S_SEND);
        o_dllp_data    = dllp_data_q;
        o_nack_pending = nack_pending_q;
    end

endmodule

// File: tb/tb_ack_nack_scheduler.sv
// Directed bench for ack_nack_scheduler: table of single-entry vectors plus multi-cycle sequences.
// Coalescing sequences run when ACK_NACK_COALESCE_EN is defined, the direct-ACK ones otherwise.
`timescale 1ns/1ps

module tb_ack_nack_scheduler;

    localparam int W = 2;
`ifdef ACK_NACK_COALESCE_EN
    localparam int ACK_LAT = 16;
`else
    localparam int ACK_LAT = 2;
`endif

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_id_result_empty;
    logic [W:0]    i_id_result;
    logic          o_id_result_rd;
    logic          o_dllp_req;
    logic          i_dllp_ack;
    logic [15:0]   o_dllp_data;
    logic          o_nack_pending;

    always #5 i_clk = ~i_clk;

    ack_nack_scheduler #(
        .TLP_ID_WIDTH    (W),
        .ACK_COALESCE_MAX(4),
        .ACK_TIMEOUT     (16)
    ) dut (
        .i_clk            (i_clk),
        .i_arst           (i_arst),
        .i_id_result_empty(i_id_result_empty),
        .i_id_result      (i_id_result),
        .o_id_result_rd   (o_id_result_rd),
        .o_dllp_req       (o_dllp_req),
        .i_dllp_ack       (i_dllp_ack),
        .o_dllp_data      (o_dllp_data),
        .o_nack_pending   (o_nack_pending)
    );

    typedef struct {
        logic [W:0]  entry;
        logic [15:0] exp_data;
        int          exp_lat;
        logic        exp_nack;
    } vec_t;

    vec_t        vecs[6];
    logic [W:0]  fifo[$];
    logic [15:0] sent[$];
    int          cyc, pop_cyc, rise_cyc, pops, req_cyc;
    int          n_chk, n_fail;
    bit          auto_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        i_id_result_empty = (fifo.size() == 0);
        i_id_result       = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic push(input logic [W:0] e);
        fifo.push_back(e);
        drive_fifo();
    endtask

    function automatic logic [15:0] sent_at(input int i);
        return (sent.size() > i) ? sent[i] : 16'hxxxx;
    endfunction

    // One clock: sample at the falling edge, apply FIFO pop and release ack just after the rising edge.
    task automatic tick();
        bit rd_s;
        @(negedge i_clk);
        rd_s = o_id_result_rd;
        if (rd_s) begin
            check("rd_while_empty", {31'd0, i_id_result_empty}, 32'd0);
            pops++;
            pop_cyc = cyc;
        end
        if (o_dllp_req) begin
            if (req_cyc == 0) rise_cyc = cyc;
            if (auto_ack) i_dllp_ack = 1'b1;
            if (i_dllp_ack) sent.push_back(o_dllp_data);
            req_cyc++;
        end else begin
            req_cyc = 0;
        end
        @(posedge i_clk);
        #1;
        i_dllp_ack = 1'b0;
        if (rd_s && fifo.size() != 0) void'(fifo.pop_front());
        drive_fifo();
        cyc++;
    endtask

    task automatic do_reset();
        i_arst     = 1'b1;
        i_dllp_ack = 1'b0;
        fifo.delete();
        drive_fifo();
        repeat (2) @(posedge i_clk);
        #1;
        i_arst  = 1'b0;
        sent.delete();
        pops    = 0;
        req_cyc = 0;
    endtask

    task automatic run_until_sent(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (sent.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({name, "_count"}, sent.size(), n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int k;
        n_chk = 0; n_fail = 0; cyc = 0; pops = 0; req_cyc = 0;
        pop_cyc = 0; rise_cyc = 0; auto_ack = 1'b0;
        i_dllp_ack = 1'b0;

        vecs[0] = '{3'b001, 16'hB001, 2,       1'b1};
        vecs[1] = '{3'b000, 16'hB000, 2,       1'b1};
        vecs[2] = '{3'b011, 16'hB003, 2,       1'b1};
        vecs[3] = '{3'b100, 16'hA000, ACK_LAT, 1'b0};
        vecs[4] = '{3'b111, 16'hA003, ACK_LAT, 1'b0};
        vecs[5] = '{3'b110, 16'hA002, ACK_LAT, 1'b0};

        // Reset held with a non-empty FIFO: nothing popped, all outputs low.
        i_arst = 1'b1;
        push(3'b011);
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_rd", {31'd0, o_id_result_rd}, 32'd0);
        check("reset_req", {31'd0, o_dllp_req}, 32'd0);
        check("reset_data", {16'd0, o_dllp_data}, 32'd0);
        check("reset_nack", {31'd0, o_nack_pending}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            auto_ack = 1'b1;
            push(vecs[i].entry);
            run_until_sent(1, 40, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_data", i), {16'd0, sent_at(0)}, {16'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_lat", i), rise_cyc - pop_cyc, vecs[i].exp_lat);
            tick();
            tick();
            check($sformatf("vec%0d_nack", i), {31'd0, o_nack_pending}, {31'd0, vecs[i].exp_nack});
        end

        // Single NACK held for five cycles without ack, then accepted.
        do_reset();
        auto_ack = 1'b0;
        push(3'b001);
        k = 0;
        while (!o_dllp_req && k < 10) begin tick(); k++; end
        check("t1_req_rise", {31'd0, o_dllp_req}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t1_hold_req%0d", i), {31'd0, o_dllp_req}, 32'd1);
            check($sformatf("t1_hold_data%0d", i), {16'd0, o_dllp_data}, 32'hB001);
        end
        check("t1_lat", rise_cyc - pop_cyc, 2);
        i_dllp_ack = 1'b1;
        tick();
        check("t1_sent", {16'd0, sent_at(0)}, 32'hB001);
        check("t1_req_drop", {31'd0, o_dllp_req}, 32'd0);
        check("t1_nack", {31'd0, o_nack_pending}, 32'd1);

        // Repeated NACK for the same id is sent once; an ACK in between re-arms it.
        do_reset();
        auto_ack = 1'b1;
        push(3'b001); push(3'b001); push(3'b001);
        repeat (20) tick();
        check("t2_one_dllp", sent.size(), 1);
        check("t2_data", {16'd0, sent_at(0)}, 32'hB001);
        check("t2_pops", pops, 3);
        check("t2_nack", {31'd0, o_nack_pending}, 32'd1);
        push(3'b110); push(3'b001);
`ifdef ACK_NACK_COALESCE_EN
        run_until_sent(2, 40, "t2_rearm");
        check("t2_second", {16'd0, sent_at(1)}, 32'hB001);
`else
        run_until_sent(3, 40, "t2_rearm");
        check("t2_ack", {16'd0, sent_at(1)}, 32'hA002);
        check("t2_second", {16'd0, sent_at(2)}, 32'hB001);
`endif
        tick();
        check("t2_nack_after", {31'd0, o_nack_pending}, 32'd1);

`ifdef ACK_NACK_COALESCE_EN
        // Four back-to-back ACKs collapse into one carrying the newest id.
        do_reset();
        auto_ack = 1'b1;
        push(3'b100); push(3'b101); push(3'b110); push(3'b111);
        run_until_sent(1, 40, "t3");
        repeat (25) tick();
        check("t3_count", sent.size(), 1);
        check("t3_data", {16'd0, sent_at(0)}, 32'hA003);
        check("t3_pops", pops, 4);
        check("t3_lat", rise_cyc - pop_cyc, 2);

        // Timeout send wins over a FIFO entry arriving in the same cycle.
        do_reset();
        auto_ack = 1'b1;
        push(3'b101);
        k = 0;
        while (pops == 0 && k < 10) begin tick(); k++; end
        while (cyc < pop_cyc + 15) tick();
        push(3'b011);
        tick();
        check("t5_no_pop", pops, 1);
        run_until_sent(2, 40, "t5");
        check("t5_first", {16'd0, sent_at(0)}, 32'hA001);
        check("t5_second", {16'd0, sent_at(1)}, 32'hB003);
`else
        // Without coalescing every ACK produces its own DLLP.
        do_reset();
        auto_ack = 1'b1;
        push(3'b100); push(3'b101);
        run_until_sent(2, 30, "t6");
        check("t6_first", {16'd0, sent_at(0)}, 32'hA000);
        check("t6_second", {16'd0, sent_at(1)}, 32'hA001);
        check("t6_pops", pops, 2);
`endif

        // Asynchronous reset in the middle of a request drops it immediately.
        do_reset();
        auto_ack = 1'b0;
        push(3'b011);
        k = 0;
        while (!o_dllp_req && k < 10) begin tick(); k++; end
        #2;
        check("t7_pre_req", {31'd0, o_dllp_req}, 32'd1);
        check("t7_pre_nack", {31'd0, o_nack_pending}, 32'd1);
        i_arst = 1'b1;
        #1;
        check("t7_req_async", {31'd0, o_dllp_req}, 32'd0);
        check("t7_nack_async", {31'd0, o_nack_pending}, 32'd0);
        check("t7_data_async", {16'd0, o_dllp_data}, 32'd0);
        do_reset();
        repeat (5) tick();
        check("t7_lost", sent.size(), 0);
        check("t7_idle_req", {31'd0, o_dllp_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
